intersection_sequencer: RTL and testbench

INTERSECTION_SEQUENCER -- requirements
Module: intersection_sequencer

---
 rtl/traffic_pkg.sv | 54 +++++
 rtl/phase_timer.sv | 40 ++++
 rtl/intersection_sequencer.sv | 167 ++++++++++++++++
 tb/tb_intersection_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared definitions for the intersection sequencer: lamp
//                color codes, phase state encoding, default phase durations
//                and lamp-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  // Lamp color codes
  localparam logic [2:0] COLOR_RED    = 3'b000;
  localparam logic [2:0] COLOR_GREEN  = 3'b001;
  localparam logic [2:0] COLOR_YELLOW = 3'b010;

  // Default phase durations, in clock cycles
  localparam int DEF_MAIN_MIN   = 8;
  localparam int DEF_SIDE_GREEN = 6;
  localparam int DEF_YELLOW     = 3;
  localparam int DEF_ALLRED     = 2;
  localparam int DEF_WALK       = 4;

  // Phase timer width; wide enough for any duration up to 256 cycles
  localparam int TMR_W = 8;

  // Phase state encoding; 3'd7 is unencoded and recovers to ST_AR2
  typedef enum logic [2:0] {
    ST_MG  = 3'd0,
    ST_MY  = 3'd1,
    ST_AR1 = 3'd2,
    ST_SG  = 3'd3,
    ST_SY  = 3'd4,
    ST_AR2 = 3'd5,
    ST_PW  = 3'd6
  } state_e;

  function automatic logic [2:0] main_lamp(input state_e s);
    case (s)
      ST_MG:   main_lamp = COLOR_GREEN;
      ST_MY:   main_lamp = COLOR_YELLOW;
      default: main_lamp = COLOR_RED;
    endcase
  endfunction

  function automatic logic [2:0] side_lamp(input state_e s);
    case (s)
      ST_SG:   side_lamp = COLOR_GREEN;
      ST_SY:   side_lamp = COLOR_YELLOW;
      default: side_lamp = COLOR_RED;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Loadable down-counter. Loads 'value' when 'load' is high,
//                otherwise decrements toward zero and holds at zero.
//                'done' flags the final cycle of the timed interval.
//  Revision    : 1.0 - initial release
//  Ports       : clk   - rising-edge clock
//                reset - synchronous active-high reset (loads RESET_VALUE)
//                load  - load strobe
//                value - value to load (duration - 1)
//                done  - counter is zero
// ============================================================================
module phase_timer #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= RESET_VALUE;
    end else if (load) begin
      tmr_q <= value;
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end

  assign done = (tmr_q == '0);

endmodule
`default_nettype wire

// File: rtl/intersection_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : intersection_sequencer
//  Description : Two-street traffic light controller with pedestrian phase.
//                Main street rests green; latched side-street or pedestrian
//                requests trigger a cycle through yellow, all-red, optional
//                walk, side green/yellow and all-red back to main green.
//  Revision    : 1.0 - initial release
//  Ports       : clk        - rising-edge clock
//                reset      - synchronous active-high reset
//                side_req   - side-street vehicle sensor (level or pulse)
//                ped_req    - pedestrian button (level or pulse)
//                main_color - main-street lamp code
//                side_color - side-street lamp code
//                walk       - pedestrian walk lamp
//                ped_ack    - one-cycle pulse at start of walk interval
// ============================================================================
module intersection_sequencer
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN   = DEF_MAIN_MIN,
  parameter int SIDE_GREEN = DEF_SIDE_GREEN,
  parameter int YELLOW     = DEF_YELLOW,
  parameter int ALLRED     = DEF_ALLRED,
  parameter int WALK       = DEF_WALK
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_color,
  output logic [2:0] side_color,
  output logic       walk,
  output logic       ped_ack
);

  // Timer load values are duration-1 so that tmr==0 is the last cycle
  localparam logic [TMR_W-1:0] c_main_load   = TMR_W'(MAIN_MIN - 1);
  localparam logic [TMR_W-1:0] c_side_load   = TMR_W'(SIDE_GREEN - 1);
  localparam logic [TMR_W-1:0] c_yellow_load = TMR_W'(YELLOW - 1);
  localparam logic [TMR_W-1:0] c_allred_load = TMR_W'(ALLRED - 1);
  localparam logic [TMR_W-1:0] c_walk_load   = TMR_W'(WALK - 1);

  state_e           state_q, state_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic [2:0]       main_color_q, side_color_q;
  logic             walk_q, ped_ack_q;
  logic             w_done;
  logic             w_adv;
  logic [TMR_W-1:0] w_load_val;

  phase_timer #(
    .WIDTH       (TMR_W),
    .RESET_VALUE (c_allred_load)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_adv),
    .value (w_load_val),
    .done  (w_done)
  );

  // Next-state logic; w_adv marks a state entry and reloads the timer
  always_comb begin
    state_d = state_q;
    w_adv   = 1'b0;
    case (state_q)
      ST_MG: begin
        // Main green rests indefinitely until a request is pending
        if (w_done && (side_pend_q || ped_pend_q)) begin
          w_adv   = 1'b1;
          state_d = ST_MY;
        end
      end
      ST_MY: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = ST_AR1;
        end
      end
      ST_AR1: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = ped_pend_q ? ST_PW : ST_SG;
        end
      end
      ST_PW: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = side_pend_q ? ST_SG : ST_AR2;
        end
      end
      ST_SG: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = ST_SY;
        end
      end
      ST_SY: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = ST_AR2;
        end
      end
      ST_AR2: begin
        if (w_done) begin
          w_adv   = 1'b1;
          state_d = ST_MG;
        end
      end
      default: begin
        // Unencoded state: recover through all-red clearance
        w_adv   = 1'b1;
        state_d = ST_AR2;
      end
    endcase
  end

  always_comb begin
    case (state_d)
      ST_MG:         w_load_val = c_main_load;
      ST_MY, ST_SY:  w_load_val = c_yellow_load;
      ST_SG:         w_load_val = c_side_load;
      ST_PW:         w_load_val = c_walk_load;
      default:       w_load_val = c_allred_load;
    endcase
  end

  // Pending requests latch every cycle; the clear on service entry
  // takes priority over a request arriving in the same cycle.
  always_comb begin
    side_pend_d = side_pend_q | side_req;
    ped_pend_d  = ped_pend_q | ped_req;
    if (w_adv && (state_d == ST_SG)) side_pend_d = 1'b0;
    if (w_adv && (state_d == ST_PW)) ped_pend_d  = 1'b0;
  end

  // Outputs are registered from the next state so that they are an exact
  // decode of the state register without an extra cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_AR2;
      side_pend_q  <= 1'b0;
      ped_pend_q   <= 1'b0;
      main_color_q <= COLOR_RED;
      side_color_q <= COLOR_RED;
      walk_q       <= 1'b0;
      ped_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      side_pend_q  <= side_pend_d;
      ped_pend_q   <= ped_pend_d;
      main_color_q <= main_lamp(state_d);
      side_color_q <= side_lamp(state_d);
      walk_q       <= (state_d == ST_PW);
      ped_ack_q    <= w_adv && (state_d == ST_PW);
    end
  end

  assign main_color = main_color_q;
  assign side_color = side_color_q;
  assign walk       = walk_q;
  assign ped_ack    = ped_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_intersection_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_intersection_sequencer
//  Description : Self-checking bench for intersection_sequencer. Directed
//                phase-length scenarios with literal expectations, then
//                randomized requests and resets checked every cycle against
//                a phase/age behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_sequencer;

  localparam int MAIN_MIN   = 8;
  localparam int SIDE_GREEN = 6;
  localparam int YELLOW     = 3;
  localparam int ALLRED     = 2;
  localparam int WALK       = 4;

  // Lamp tags {main, side, walk}
  localparam logic [6:0] TAG_MG  = 7'b001_000_0;
  localparam logic [6:0] TAG_MY  = 7'b010_000_0;
  localparam logic [6:0] TAG_SG  = 7'b000_001_0;
  localparam logic [6:0] TAG_SY  = 7'b000_010_0;
  localparam logic [6:0] TAG_PW  = 7'b000_000_1;
  localparam logic [6:0] TAG_RED = 7'b000_000_0;

  // Model phase identifiers
  localparam int P_MG = 0, P_MY = 1, P_AR1 = 2, P_SG = 3, P_SY = 4, P_AR2 = 5, P_PW = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] main_color, side_color;
  logic       walk, ped_ack;

  int checks = 0;
  int errors = 0;

  intersection_sequencer #(
    .MAIN_MIN(MAIN_MIN), .SIDE_GREEN(SIDE_GREEN), .YELLOW(YELLOW),
    .ALLRED(ALLRED), .WALK(WALK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_color (main_color),
    .side_color (side_color),
    .walk       (walk),
    .ped_ack    (ped_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] lamps();
    return {main_color, side_color, walk};
  endfunction

  // Checks that the current negedge and the next len-1 show the given tag;
  // leaves the bench at the negedge following the run.
  task automatic expect_run(input string name, input logic [6:0] tag, input int len);
    int good = 0;
    for (int i = 0; i < len; i++) begin
      if (lamps() === tag) good++;
      @(negedge clk);
    end
    check(name, good, len);
  endtask

  // Pulse reset for one edge and walk through the all-red clearance;
  // returns at the negedge of main-green cycle 1.
  task automatic do_reset();
    reset = 1'b1;
    side_req = 1'b0;
    ped_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    expect_run("ar2_after_reset", TAG_RED, ALLRED);
  endtask

  // ---------------- behavioural model ----------------
  int m_ph, m_age;
  bit m_sp, m_pp, m_valid = 1'b0;

  function automatic int dur_of(input int ph);
    case (ph)
      P_MG:        return MAIN_MIN;
      P_MY, P_SY:  return YELLOW;
      P_SG:        return SIDE_GREEN;
      P_PW:        return WALK;
      default:     return ALLRED;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_ph = P_AR2; m_age = 1; m_sp = 0; m_pp = 0; m_valid = 1;
    end else if (m_valid) begin
      bit leave;
      int nxt;
      bit sp_n, pp_n;
      leave = (m_age >= dur_of(m_ph)) && (m_ph != P_MG || m_sp || m_pp);
      case (m_ph)
        P_MG:  nxt = P_MY;
        P_MY:  nxt = P_AR1;
        P_AR1: nxt = m_pp ? P_PW : P_SG;
        P_PW:  nxt = m_sp ? P_SG : P_AR2;
        P_SG:  nxt = P_SY;
        P_SY:  nxt = P_AR2;
        default: nxt = P_MG;
      endcase
      sp_n = m_sp | side_req;
      pp_n = m_pp | ped_req;
      if (leave) begin
        if (nxt == P_SG) sp_n = 0;
        if (nxt == P_PW) pp_n = 0;
        m_ph = nxt;
        m_age = 1;
      end else begin
        m_age++;
      end
      m_sp = sp_n;
      m_pp = pp_n;
    end
  end

  // Per-cycle compare against the model, plus lamp-conflict safety
  always @(negedge clk) begin
    if (m_valid) begin
      logic [2:0] em, es;
      em = (m_ph == P_MG) ? 3'b001 : (m_ph == P_MY) ? 3'b010 : 3'b000;
      es = (m_ph == P_SG) ? 3'b001 : (m_ph == P_SY) ? 3'b010 : 3'b000;
      check("model_main", main_color, em);
      check("model_side", side_color, es);
      check("model_walk", walk, (m_ph == P_PW));
      check("model_ack", ped_ack, (m_ph == P_PW) && (m_age == 1));
      check("safety", ((main_color != 0) && (side_color != 0)) ||
                      (walk && ((main_color != 0) || (side_color != 0))), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset state and idle main-green rest
    @(negedge clk);
    @(negedge clk);
    check("reset_main", main_color, 3'b000);
    check("reset_side", side_color, 3'b000);
    check("reset_walk", walk, 1'b0);
    check("reset_ack", ped_ack, 1'b0);
    reset = 1'b0;
    expect_run("idle_ar2", TAG_RED, 2);
    expect_run("idle_mg_hold", TAG_MG, 50);

    // Side pulse in MG cycle 3
    do_reset();
    expect_run("s1_mg_a", TAG_MG, 2);
    side_req = 1'b1;
    expect_run("s1_mg_b", TAG_MG, 1);
    side_req = 1'b0;
    expect_run("s1_mg_c", TAG_MG, 5);
    expect_run("s1_my", TAG_MY, 3);
    expect_run("s1_ar1", TAG_RED, 2);
    expect_run("s1_sg", TAG_SG, 6);
    expect_run("s1_sy", TAG_SY, 3);
    expect_run("s1_ar2", TAG_RED, 2);
    expect_run("s1_mg_back", TAG_MG, 1);

    // Pedestrian only
    do_reset();
    ped_req = 1'b1;
    expect_run("s2_mg_a", TAG_MG, 1);
    ped_req = 1'b0;
    expect_run("s2_mg_b", TAG_MG, 7);
    expect_run("s2_my", TAG_MY, 3);
    expect_run("s2_ar1", TAG_RED, 2);
    check("s2_ack_first", ped_ack, 1'b1);
    expect_run("s2_pw", TAG_PW, 4);
    expect_run("s2_ar2", TAG_RED, 2);
    expect_run("s2_mg_back", TAG_MG, 3);

    // Side and pedestrian together
    do_reset();
    side_req = 1'b1;
    ped_req = 1'b1;
    expect_run("s3_mg_a", TAG_MG, 1);
    side_req = 1'b0;
    ped_req = 1'b0;
    expect_run("s3_mg_b", TAG_MG, 7);
    expect_run("s3_my", TAG_MY, 3);
    expect_run("s3_ar1", TAG_RED, 2);
    expect_run("s3_pw", TAG_PW, 4);
    expect_run("s3_sg", TAG_SG, 6);
    expect_run("s3_sy", TAG_SY, 3);
    expect_run("s3_ar2", TAG_RED, 2);
    expect_run("s3_mg_back", TAG_MG, 1);

    // Reset in SG cycle 3 discards the phase and a pedestrian request
    do_reset();
    side_req = 1'b1;
    expect_run("s4_mg_a", TAG_MG, 1);
    side_req = 1'b0;
    expect_run("s4_mg_b", TAG_MG, 7);
    expect_run("s4_my", TAG_MY, 3);
    expect_run("s4_ar1", TAG_RED, 2);
    expect_run("s4_sg12", TAG_SG, 2);
    check("s4_sg3", lamps(), TAG_SG);
    ped_req = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("s4_reset_lamps", lamps(), TAG_RED);
    check("s4_reset_ack", ped_ack, 1'b0);
    reset = 1'b0;
    ped_req = 1'b0;
    expect_run("s4_ar2", TAG_RED, 2);
    expect_run("s4_mg_hold", TAG_MG, 20);

    // Side request held high: relatches after SG entry
    do_reset();
    side_req = 1'b1;
    expect_run("s5_mg1", TAG_MG, 8);
    expect_run("s5_my1", TAG_MY, 3);
    expect_run("s5_ar1", TAG_RED, 2);
    expect_run("s5_sg", TAG_SG, 6);
    expect_run("s5_sy", TAG_SY, 3);
    expect_run("s5_ar2", TAG_RED, 2);
    expect_run("s5_mg2", TAG_MG, 8);
    expect_run("s5_my2", TAG_MY, 1);
    side_req = 1'b0;

    // Randomized requests and occasional resets, model-checked
    for (int i = 0; i < 4000; i++) begin
      side_req = ($urandom_range(0, 9) == 0);
      ped_req  = ($urandom_range(0, 13) == 0);
      reset    = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    side_req = 1'b0;
    ped_req = 1'b0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
